// File: rtl/axi_sram_if.sv
// AXI4 bus bundle between the crossbar master port and the SRAM responder.
// Address, data and ID widths are parameters; sideband fields travel with the bundle but are unused by the memory.
interface axi_sram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 9
);
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic [3:0]            awqos;
  logic [3:0]            awregion;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;
  logic [3:0]            arregion;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 SRAM responder: independent read and write burst engines (FIXED/INCR/WRAP) over a byte-masked
// synchronous RAM. IDs are reflected and every response is OKAY.
module axi_sram_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  axi_sram_if.slave    s_axi
);

  localparam int LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_W = ADDR_WIDTH - LSB;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_BURST}        r_state_e;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] inc;
    step = ADDR_WIDTH'(1) << size;
    mask = ADDR_WIDTH'(((32'(len) + 32'd1) << size) - 32'd1);
    inc  = addr + step;
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (addr & ~mask) | (inc & mask);
      default: next_addr = inc;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // ---------------- write path ----------------
  w_state_e              r_wstate, w_wstate_nxt;
  logic                  r_awready;
  logic [ID_WIDTH-1:0]   r_awid;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_awlen, r_wcnt;
  logic [2:0]            r_awsize;
  logic [1:0]            r_awburst;
  logic                  w_wready, w_bvalid;
  logic                  w_aw_hs, w_w_hs, w_b_hs;
  logic [IDX_W-1:0]      w_widx;

  assign w_aw_hs = s_axi.awvalid & r_awready;
  assign w_w_hs  = s_axi.wvalid  & w_wready;
  assign w_b_hs  = s_axi.bready  & w_bvalid;
  assign w_widx  = r_waddr[ADDR_WIDTH-1:LSB];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE);
    end
  end

  // NOTE: next-state is defaulted first so no path through the case can infer a latch.
  always_comb begin
    w_wstate_nxt = r_wstate;
    unique case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && (r_wcnt == r_awlen)) w_wstate_nxt = W_RESP;
      W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_wready = (r_wstate == W_DATA);
    w_bvalid = (r_wstate == W_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_awid    <= '0;
      r_waddr   <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
      r_wcnt    <= '0;
    end else if (w_aw_hs) begin
      r_awid    <= s_axi.awid;
      r_waddr   <= s_axi.awaddr;
      r_awlen   <= s_axi.awlen;
      r_awsize  <= s_axi.awsize;
      r_awburst <= s_axi.awburst;
      r_wcnt    <= '0;
    end else if (w_w_hs) begin
      r_waddr   <= next_addr(r_waddr, r_awlen, r_awsize, r_awburst);
      r_wcnt    <= r_wcnt + 8'd1;
    end
  end

  // NOTE: the RAM array has no reset; its contents deliberately survive rst_n.
  always_ff @(posedge clk) begin
    if (w_w_hs) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi.wstrb[b]) r_mem[w_widx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_e              r_rstate, w_rstate_nxt;
  logic                  r_arready;
  logic [ID_WIDTH-1:0]   r_arid;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]            r_arlen, r_rcnt;
  logic [2:0]            r_arsize;
  logic [1:0]            r_arburst;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_rvalid, w_rlast;
  logic                  w_ar_hs, w_r_hs;

  assign w_ar_hs = s_axi.arvalid & r_arready;
  assign w_r_hs  = s_axi.rready  & w_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    unique case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_BURST;
      R_BURST: if (w_r_hs && w_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_rvalid = (r_rstate == R_BURST);
    w_rlast  = w_rvalid && (r_rcnt == r_arlen);
  end

  // r_raddr always points at the beat after the one currently presented on rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arid    <= '0;
      r_raddr   <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_rcnt    <= '0;
      r_rdata   <= '0;
    end else if (w_ar_hs) begin
      r_arid    <= s_axi.arid;
      r_arlen   <= s_axi.arlen;
      r_arsize  <= s_axi.arsize;
      r_arburst <= s_axi.arburst;
      r_rcnt    <= '0;
      r_rdata   <= r_mem[s_axi.araddr[ADDR_WIDTH-1:LSB]];
      r_raddr   <= next_addr(s_axi.araddr, s_axi.arlen, s_axi.arsize, s_axi.arburst);
    end else if (w_r_hs && !w_rlast) begin
      r_rcnt    <= r_rcnt + 8'd1;
      r_rdata   <= r_mem[r_raddr[ADDR_WIDTH-1:LSB]];
      r_raddr   <= next_addr(r_raddr, r_arlen, r_arsize, r_arburst);
    end
  end

  // ---------------- outputs ----------------
  assign s_axi.awready = r_awready;
  assign s_axi.wready  = w_wready;
  assign s_axi.bvalid  = w_bvalid;
  assign s_axi.bid     = r_awid;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = w_rvalid;
  assign s_axi.rid     = r_arid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = 2'b00;
  assign s_axi.rlast   = w_rlast;

  logic w_unused_sideband;
  assign w_unused_sideband = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos, s_axi.awregion,
                               s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos, s_axi.arregion,
                               s_axi.wlast};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: reset behaviour, INCR/WRAP/FIXED bursts, strobes,
// B/R backpressure and reset in the middle of a read burst.
module tb_axi_sram_slave;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] ebuf [16];

  always #5 clk = ~clk;

  axi_sram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(9)) bus ();

  axi_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .ID_WIDTH(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_axi (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic sig_sel(input int sel);
    case (sel)
      0:       sig_sel = bus.awready;
      1:       sig_sel = bus.wready;
      2:       sig_sel = bus.bvalid;
      3:       sig_sel = bus.arready;
      default: sig_sel = bus.rvalid;
    endcase
  endfunction

  // Waits (bounded) until the selected signal is high at a falling edge.
  task automatic wait_high(input int sel, input string tag);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (sig_sel(sel) === 1'b1) return;
    end
    check(tag, 64'd0, 64'd1);
  endtask

  task automatic axi_write(input logic [8:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int b_hold);
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    wait_high(0, "aw_timeout");
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    check("wready_lat", bus.wready, 1'b1);
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata = wbuf[i]; bus.wstrb = sbuf[i]; bus.wlast = (i == int'(len)); bus.wvalid = 1'b1;
      wait_high(1, "w_timeout");
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("bvalid_lat", bus.bvalid, 1'b1);
    bus.bready = (b_hold == 0);
    wait_high(2, "b_timeout");
    check("bid", bus.bid, id);
    check("bresp", bus.bresp, 2'b00);
    for (int k = 0; k < b_hold; k++) begin
      @(posedge clk); #1;
      check("b_held", bus.bvalid, 1'b1);
      check("aw_blocked", bus.awready, 1'b0);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    check("b_done", bus.bvalid, 1'b0);
    check("awready_back", bus.awready, 1'b1);
  endtask

  task automatic axi_read(input logic [8:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] pat);
    int beat;
    int cyc;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    wait_high(3, "ar_timeout");
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    check("rvalid_lat", bus.rvalid, 1'b1);
    beat = 0;
    cyc  = 0;
    while (beat <= int'(len) && cyc < 300) begin
      bus.rready = pat[3 - (cyc % 4)];
      @(negedge clk);
      if (bus.rvalid) begin
        check($sformatf("rdata[%0d]", beat), bus.rdata, ebuf[beat]);
        check("rid", bus.rid, id);
        check("rresp", bus.rresp, 2'b00);
        check($sformatf("rlast[%0d]", beat), bus.rlast, beat == int'(len));
        if (bus.rready) beat++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.rready = 1'b0;
    if (cyc >= 300) check("r_timeout", 64'd0, 64'd1);
    check("r_end", bus.rvalid, 1'b0);
    check("arready_back", bus.arready, 1'b1);
  endtask

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awregion = '0;
    bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arregion = '0;
    bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state and release
    #22;
    check("rst_awready", bus.awready, 1'b0);
    check("rst_arready", bus.arready, 1'b0);
    check("rst_wready", bus.wready, 1'b0);
    check("rst_bvalid", bus.bvalid, 1'b0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_rlast", bus.rlast, 1'b0);
    check("rst_ids", {bus.bid, bus.rid}, 18'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_resp", {bus.bresp, bus.rresp}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("awready_pre_edge", bus.awready, 1'b0);
    @(posedge clk); #1;
    check("awready_up", bus.awready, 1'b1);
    check("arready_up", bus.arready, 1'b1);
    check("bvalid_idle", bus.bvalid, 1'b0);
    check("rvalid_idle", bus.rvalid, 1'b0);

    // INCR write then read back
    wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222; wbuf[2] = 32'h3333_3333; wbuf[3] = 32'h4444_4444;
    for (int i = 0; i < 4; i++) begin sbuf[i] = 4'hF; ebuf[i] = wbuf[i]; end
    axi_write(9'h005, 16'h0100, 8'd3, 3'd2, 2'b01, 0);
    axi_read(9'h005, 16'h0100, 8'd3, 3'd2, 2'b01, 4'b1111);

    // WRAP read over a preloaded 16-byte block
    wbuf[0] = 32'hA000_0020; wbuf[1] = 32'hA000_0024; wbuf[2] = 32'hA000_0028; wbuf[3] = 32'hA000_002C;
    axi_write(9'h1A3, 16'h0020, 8'd3, 3'd2, 2'b01, 0);
    ebuf[0] = 32'hA000_0028; ebuf[1] = 32'hA000_002C; ebuf[2] = 32'hA000_0020; ebuf[3] = 32'hA000_0024;
    axi_read(9'h0C2, 16'h0028, 8'd3, 3'd2, 2'b10, 4'b1111);

    // Partial strobes over a zeroed word, then FIXED read
    wbuf[0] = 32'h0000_0000; sbuf[0] = 4'hF;
    axi_write(9'h010, 16'h0040, 8'd0, 3'd2, 2'b01, 0);
    wbuf[0] = 32'hAABB_CCDD; sbuf[0] = 4'h5;
    axi_write(9'h011, 16'h0040, 8'd0, 3'd2, 2'b01, 0);
    ebuf[0] = 32'h00BB_00DD; ebuf[1] = 32'h00BB_00DD;
    axi_read(9'h012, 16'h0040, 8'd1, 3'd2, 2'b00, 4'b1111);

    // Backpressure: B held 5 cycles, R accepted every other cycle
    wbuf[0] = 32'hDEAD_0001; wbuf[1] = 32'hDEAD_0002; wbuf[2] = 32'hDEAD_0003;
    for (int i = 0; i < 3; i++) begin sbuf[i] = 4'hF; ebuf[i] = wbuf[i]; end
    axi_write(9'h111, 16'h0300, 8'd2, 3'd2, 2'b01, 5);
    axi_read(9'h0AA, 16'h0300, 8'd2, 3'd2, 2'b01, 4'b1010);

    // Reset in the middle of an 8-beat read (while beat 2 is presented)
    for (int i = 0; i < 8; i++) begin wbuf[i] = 32'hC0DE_0000 + i; sbuf[i] = 4'hF; ebuf[i] = wbuf[i]; end
    axi_write(9'h033, 16'h0200, 8'd7, 3'd2, 2'b01, 0);
    bus.arid = 9'h044; bus.araddr = 16'h0200; bus.arlen = 8'd7; bus.arsize = 3'd2; bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    wait_high(3, "ar_timeout");
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("mid_rdata[%0d]", i), bus.rdata, ebuf[i]);
      @(posedge clk); #1;
    end
    bus.rready = 1'b0;
    @(negedge clk);
    check("mid_rdata[2]", bus.rdata, ebuf[2]);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", bus.rvalid, 1'b0);
    check("mid_rst_rdata", bus.rdata, 32'd0);
    check("mid_rst_arready", bus.arready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(9'h045, 16'h0200, 8'd7, 3'd2, 2'b01, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI4 memory responder that terminates the single master port of the crossbar (the 9-bit-ID side) with on-chip synchronous RAM. It accepts FIXED/INCR/WRAP bursts on independent read and write paths, reflects transaction IDs, and always returns OKAY. It is the default memory target for NPU weight and feature buffers behind the crossbar.

## Interface
- DATA_WIDTH, 32: data bus width in bits, power of two ≥ 8.
- ADDR_WIDTH, 16: byte-address bits decoded. Memory depth = 2^ADDR_WIDTH bytes. Upper bits of wider crossbar addresses are dropped by the instantiator.
- STRB_WIDTH, DATA_WIDTH/8: write strobe width.
- ID_WIDTH, 9: AXI ID width. Matches crossbar S_ID_WIDTH+1.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_axi_awid / awaddr / awlen / awsize / awburst  in  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2  write address fields.
- s_axi_awvalid  in  1; s_axi_awready  out  1.
- s_axi_wdata / wstrb / wlast  in  DATA_WIDTH / STRB_WIDTH / 1  write data.
- s_axi_wvalid  in  1; s_axi_wready  out  1.
- s_axi_bid / bresp  out  ID_WIDTH / 2  write response.
- s_axi_bvalid  out  1; s_axi_bready  in  1.
- s_axi_arid / araddr / arlen / arsize / arburst  in  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2  read address fields.
- s_axi_arvalid  in  1; s_axi_arready  out  1.
- s_axi_rid / rdata / rresp / rlast  out  ID_WIDTH / DATA_WIDTH / 2 / 1  read data.
- s_axi_rvalid  out  1; s_axi_rready  in  1.
- s_axi_{aw,ar}{lock,cache,prot,qos,region}  in  1/4/3/4/4  accepted and ignored.

## Operation
- Word index = addr[ADDR_WIDTH-1 : log2(STRB_WIDTH)]. Addresses wrap modulo memory size.
- Next-address rule, step = 1<<size:
  - FIXED (0): address unchanged.
  - INCR (1) and reserved (3): addr + step, ADDR_WIDTH-bit truncation.
  - WRAP (2): mask = ((len+1)<<size)-1; next = (addr & ~mask) | ((addr+step) & mask).
- Narrow sizes are allowed. Writes apply wstrb exactly as given. Reads return the full word.
- Write FSM: W_IDLE → W_DATA on AW handshake. Captures id, addr, len, size, burst; beat count = 0.
  - W_DATA: wready=1. Each W handshake writes the bytes selected by wstrb, then advances address and count.
  - The handshake on beat count == awlen moves to W_RESP. wlast is ignored; the awlen count governs.
  - W_RESP: bvalid=1, bid = captured id, bresp=2'b00. Holds until bready, then returns to W_IDLE.
- Read FSM: R_IDLE → R_BURST on AR handshake. The RAM reads beat 0 (from araddr) on the same edge.
  - R_BURST: rvalid=1, rid = captured id, rresp=2'b00, rlast=1 on beat count == arlen.
  - On each R handshake the next beat's word is read on that edge. The final beat's handshake returns to R_IDLE.
- Read and write paths are fully independent and may run concurrently.
- Same-word read and write on the same edge: read returns the old data (read-before-write).
- W beats offered before the AW handshake stall (wready=0).

## Timing
- Reset (rst_n low, asynchronous): both FSMs go to idle and every output goes to 0, including awready, arready, wready, bvalid, rvalid, rlast, and all id/data/resp outputs. RAM contents are not cleared.
- awready and arready are registered:
  - Each rises on the first clk edge after rst_n deasserts.
  - Each falls on its handshake edge.
  - awready re-rises on the B-handshake edge; arready re-rises on the last-R-handshake edge.
- Write path:
  - AW handshake at edge N: wready=1 from N.
  - A single-beat W at edge N+1 gives bvalid=1 from N+1.
  - The B handshake at edge N+2 at earliest gives awready=1 after N+2.
  - Best case, one write burst every (len+3) cycles.
- Read path:
  - AR handshake at edge N: rvalid=1 with beat 0 data after N (1-cycle latency).
  - With rready held high, one beat per cycle.
  - rdata/rid/rlast stay stable while rvalid && !rready.
- No combinational path from any valid or ready input to any output.

## Test plan
- Reset release: all outputs 0 during reset; awready=arready=1 one edge after release; bvalid=rvalid=0.
- INCR write then read: write id=0x05, addr 0x0100, len=3, size=2, data 0x11111111…0x44444444, strobes 0xF. Required: bid=0x05, bresp=0; read returns the same four words, rlast only on the 4th beat, rid=0x05.
- WRAP read: preload words 0x20..0x2C; read addr 0x0028, len=3, size=2. Required: word order 0x28, 0x2C, 0x20, 0x24.
- Strobes/FIXED: write 0xAABBCCDD to 0x0040 with wstrb=0x5 over a word of 0; FIXED len=1 read returns 0x00BB00DD twice.
- Backpressure: hold bready=0 for 5 cycles and toggle rready 1010. Required: bvalid held with no new AW accepted; R fields stable while stalled; no beats lost.
- Concurrency/reset: reset mid-read at beat 2 of 8. Required: rvalid=0 immediately; new read after release starts at beat 0; RAM data intact.
